branch_predict_tournament: RTL and testbench

Tournament branch predictor for the ID stage, superseding the single-level-local PHT predictor. It combines three parts: a per-PC local-history predictor, a gshare global-history predictor, and a per-PC chooser that picks between them. It also keeps a speculative global history register (GHR) with mispredict recovery, and initialises its tables with a sweep FSM instead of a one-cycle array reset. Prediction is made in D; training happens in M from resolved branches.

---
 rtl/branch_predict_tournament.sv | 196 +++++++++++++++++++
 tb/tb_branch_predict_tournament.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor for the ID stage.
// Combines a per-PC local-history predictor, a gshare global predictor and a
// per-PC chooser. Keeps a speculative global history register with mispredict
// recovery, and initialises every table with a sweep after reset.
//
// Optional feature macro: BP_GLOBAL_EN
//   defined   -> GHR, gshare PHT, chooser and recovery are built in.
//   undefined -> local predictor only; ghrD is tied to 0, ghrM/pred_takeM unused.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instrD, pcD       instruction and PC in D (lookup side)
//   stallD            D stalled; blocks the speculative GHR shift
//   pcM, branchM      PC of the instruction in M, and whether it is a branch
//   actual_takeM      resolved direction of the branch in M
//   pred_takeM, ghrM  prediction and GHR snapshot carried down from D
//   branchD           decoded branch in D
//   branchL_D         decoded branch-likely in D
//   pred_takeD        predicted direction (combinational)
//   ghrD              GHR value used for this lookup
//   bp_ready          table initialisation complete
module branch_predict_tournament #(
    parameter int unsigned BHT_DEPTH  = 10,
    parameter int unsigned LHIST_W    = 6,
    parameter int unsigned GHR_W      = 8,
    parameter int unsigned CPHT_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instrD,
    input  logic [31:0]      pcD,
    input  logic             stallD,
    input  logic [31:0]      pcM,
    input  logic             branchM,
    input  logic             actual_takeM,
    input  logic             pred_takeM,
    input  logic [GHR_W-1:0] ghrM,
    output logic             branchD,
    output logic             branchL_D,
    output logic             pred_takeD,
    output logic [GHR_W-1:0] ghrD,
    output logic             bp_ready
);
    localparam int unsigned LOCAL_MAX  = (BHT_DEPTH > LHIST_W) ? BHT_DEPTH : LHIST_W;
`ifdef BP_GLOBAL_EN
    localparam int unsigned GLOBAL_MAX = (GHR_W > CPHT_DEPTH) ? GHR_W : CPHT_DEPTH;
    localparam int unsigned CNT_W      = (LOCAL_MAX > GLOBAL_MAX) ? LOCAL_MAX : GLOBAL_MAX;
    localparam int unsigned GPHT_N     = 2 ** GHR_W;
    localparam int unsigned CPHT_N     = 2 ** CPHT_DEPTH;
`else
    localparam int unsigned CNT_W      = LOCAL_MAX;
`endif
    localparam int unsigned BHT_N      = 2 ** BHT_DEPTH;
    localparam int unsigned LPHT_N     = 2 ** LHIST_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic [LHIST_W-1:0] bht  [BHT_N];
    logic [1:0]         lpht [LPHT_N];

    // 2-bit saturating step toward 'up'
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'd3) ? c : 2'(c + 2'd1);
        end
        return (c == 2'd0) ? c : 2'(c - 2'd1);
    endfunction

    // Branch decode: REGIMM with rt[4:2] in {000,001}, or opcode[31:28]==0001
    always_comb begin
        logic       is_regimm;
        logic [2:0] rt_hi;
        is_regimm = (instrD[31:26] == 6'b000001);
        rt_hi     = instrD[20:18];
        branchD   = (is_regimm && (rt_hi == 3'b000 || rt_hi == 3'b001))
                  || (instrD[31:28] == 4'b0001);
        branchL_D = is_regimm && (rt_hi == 3'b001);
    end

    // Init/run state register; cnt walks every table entry during INIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            cnt      <= '0;
            bp_ready <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= (state == ST_INIT) ? CNT_W'(cnt + CNT_W'(1)) : cnt;
            bp_ready <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (cnt == '1) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // D-stage local lookup
    logic [BHT_DEPTH-1:0] bht_idx_d;
    logic [LHIST_W-1:0]   lhist_d;
    logic                 local_d;
    logic                 dir_d;

    assign bht_idx_d = pcD[BHT_DEPTH+1:2];
    assign lhist_d   = bht[bht_idx_d];
    assign local_d   = lpht[lhist_d][1];

    // M-stage training reads (indices rebuilt from pcM/ghrM)
    logic                 train;
    logic [BHT_DEPTH-1:0] bht_idx_m;
    logic [LHIST_W-1:0]   lhist_m;
    logic                 local_m;

    assign train     = bp_ready & branchM & ~rst;
    assign bht_idx_m = pcM[BHT_DEPTH+1:2];
    assign lhist_m   = bht[bht_idx_m];
    assign local_m   = lpht[lhist_m][1];

    // Local tables: init sweep, else train from M
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            bht[cnt[BHT_DEPTH-1:0]] <= '0;
            lpht[cnt[LHIST_W-1:0]]  <= 2'd2;
        end else if (train) begin
            bht[bht_idx_m] <= {lhist_m[LHIST_W-2:0], actual_takeM};
            lpht[lhist_m]  <= sat_step(lpht[lhist_m], actual_takeM);
        end
    end

`ifdef BP_GLOBAL_EN
    logic [GHR_W-1:0]      ghr;
    logic [1:0]            gpht [GPHT_N];
    logic [1:0]            cpht [CPHT_N];
    logic [GHR_W-1:0]      gidx_d;
    logic [CPHT_DEPTH-1:0] cidx_d;
    logic [GHR_W-1:0]      gidx_m;
    logic [CPHT_DEPTH-1:0] cidx_m;
    logic                  global_m;

    assign gidx_d   = pcD[GHR_W+1:2] ^ ghr;
    assign cidx_d   = pcD[CPHT_DEPTH+1:2];
    assign gidx_m   = pcM[GHR_W+1:2] ^ ghrM;
    assign cidx_m   = pcM[CPHT_DEPTH+1:2];
    assign global_m = gpht[gidx_m][1];

    // Chooser bit 1 selects the gshare prediction
    assign dir_d = cpht[cidx_d][1] ? gpht[gidx_d][1] : local_d;
    assign ghrD  = ghr;

    // Speculative GHR; recovery from M wins over the D shift
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (bp_ready) begin
            if (branchM && (pred_takeM != actual_takeM)) begin
                ghr <= {ghrM[GHR_W-2:0], actual_takeM};
            end else if (branchD && !stallD) begin
                ghr <= {ghr[GHR_W-2:0], pred_takeD};
            end
        end
    end

    // Global tables; chooser only moves when the two predictors disagreed
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            gpht[cnt[GHR_W-1:0]]      <= 2'd2;
            cpht[cnt[CPHT_DEPTH-1:0]] <= 2'd1;
        end else if (train) begin
            gpht[gidx_m] <= sat_step(gpht[gidx_m], actual_takeM);
            if (local_m != global_m) begin
                cpht[cidx_m] <= sat_step(cpht[cidx_m], global_m == actual_takeM);
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{instrD, pcD, pcM};
`else
    assign dir_d = local_d;
    assign ghrD  = '0;

    logic unused_bits;
    assign unused_bits = ^{instrD, pcD, pcM, ghrM, pred_takeM, local_m};
`endif

    assign pred_takeD = bp_ready & branchD & dir_d;

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Self-checking bench for branch_predict_tournament: directed scenarios plus
// randomized traffic, all compared against a table-level reference model.
module tb_branch_predict_tournament;
    localparam int INIT_LEN = 1024;
    localparam logic [31:0] BEQ = 32'h1000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        stallD;
    logic [31:0] pcM;
    logic        branchM;
    logic        actual_takeM;
    logic        pred_takeM;
    logic [7:0]  ghrM;
    logic        branchD;
    logic        branchL_D;
    logic        pred_takeD;
    logic [7:0]  ghrD;
    logic        bp_ready;

    int n_checks;
    int n_fail;

    branch_predict_tournament dut (
        .clk          (clk),
        .rst          (rst),
        .instrD       (instrD),
        .pcD          (pcD),
        .stallD       (stallD),
        .pcM          (pcM),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pred_takeM   (pred_takeM),
        .ghrM         (ghrM),
        .branchD      (branchD),
        .branchL_D    (branchL_D),
        .pred_takeD   (pred_takeD),
        .ghrD         (ghrD),
        .bp_ready     (bp_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer tables
    int m_bht  [1024];
    int m_lpht [64];
    int m_gpht [256];
    int m_cpht [256];
    int m_ghr;
    bit m_ready;
    int m_init_left;

    function automatic bit is_branch(input logic [31:0] i);
        int op;
        int rt;
        op = int'(i >> 26);
        rt = int'((i >> 16) & 32'h1f);
        return (op == 1 && rt / 4 <= 1) || ((i >> 28) == 32'd1);
    endfunction

    function automatic bit is_likely(input logic [31:0] i);
        int op;
        int rt;
        op = int'(i >> 26);
        rt = int'((i >> 16) & 32'h1f);
        return op == 1 && rt / 4 == 1;
    endfunction

    function automatic int sat(input int v, input bit up);
        if (up) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic bit m_predict(input logic [31:0] pc, input logic [31:0] instr);
        int w;
        bit loc;
`ifdef BP_GLOBAL_EN
        bit glb;
`endif
        if (!m_ready || !is_branch(instr)) return 1'b0;
        w   = int'(pc >> 2);
        loc = m_lpht[m_bht[w % 1024]] >= 2;
`ifdef BP_GLOBAL_EN
        glb = m_gpht[(w % 256) ^ m_ghr] >= 2;
        if (m_cpht[w % 256] >= 2) return glb;
`endif
        return loc;
    endfunction

    task automatic m_reset();
        m_ready     = 1'b0;
        m_ghr       = 0;
        m_init_left = INIT_LEN;
        for (int i = 0; i < 1024; i++) m_bht[i] = 0;
        for (int i = 0; i < 64; i++) m_lpht[i] = 2;
        for (int i = 0; i < 256; i++) begin
            m_gpht[i] = 2;
            m_cpht[i] = 1;
        end
    endtask

    // One clock edge of the model, using the inputs currently driven
    task automatic m_tick();
        int bi;
        int h;
        bit lb;
`ifdef BP_GLOBAL_EN
        bit p;
        bit gb;
        int gi;
        int ci;
`endif
        if (rst) begin
            m_reset();
            return;
        end
        if (!m_ready) begin
            m_init_left--;
            if (m_init_left == 0) m_ready = 1'b1;
            return;
        end
`ifdef BP_GLOBAL_EN
        p = m_predict(pcD, instrD);
`endif
        if (branchM) begin
            bi = int'(pcM >> 2) % 1024;
            h  = m_bht[bi];
            lb = m_lpht[h] >= 2;
`ifdef BP_GLOBAL_EN
            ci = int'(pcM >> 2) % 256;
            gi = ci ^ int'(ghrM);
            gb = m_gpht[gi] >= 2;
            if (lb != gb) m_cpht[ci] = sat(m_cpht[ci], gb == actual_takeM);
            m_gpht[gi] = sat(m_gpht[gi], actual_takeM);
`endif
            m_lpht[h] = sat(m_lpht[h], actual_takeM);
            m_bht[bi] = (h * 2 + int'(actual_takeM)) % 64;
            if (lb) m_bht[bi] = m_bht[bi];
        end
`ifdef BP_GLOBAL_EN
        if (branchM && (pred_takeM != actual_takeM))
            m_ghr = (int'(ghrM) * 2 + int'(actual_takeM)) % 256;
        else if (is_branch(instrD) && !stallD)
            m_ghr = (m_ghr * 2 + int'(p)) % 256;
`endif
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit stall,
                         input bit bm, input logic [31:0] pcm, input bit act, input bit pm,
                         input logic [7:0] gm);
        instrD       = ins;
        pcD          = pc;
        stallD       = stall;
        branchM      = bm;
        pcM          = pcm;
        actual_takeM = act;
        pred_takeM   = pm;
        ghrM         = gm;
    endtask

    // Sample just after the falling edge, compare everything against the model
    task automatic settle();
        #1;
        check("branchD",    32'(branchD),    32'(is_branch(instrD)));
        check("branchL_D",  32'(branchL_D),  32'(is_likely(instrD)));
        check("pred_takeD", 32'(pred_takeD), 32'(m_predict(pcD, instrD)));
        check("ghrD",       32'(ghrD),       32'(m_ghr));
        check("bp_ready",   32'(bp_ready),   32'(m_ready));
    endtask

    task automatic advance();
        @(posedge clk);
        m_tick();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    bit          act;
    bit          p;
    logic [7:0]  g;
    logic [31:0] ins;
    int          r;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_reset();
        rst = 1'b1;
        drive(NOP, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        #1;
        advance();
        rst = 1'b0;

        // Init sweep: beq in D predicts not-taken until the sweep completes
        for (int i = 0; i < INIT_LEN; i++) begin
            drive(BEQ, 32'($urandom_range(0, 255)) << 2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
            settle();
            if (i == 0) check("reset_ghr", 32'(ghrD), 32'h0);
            check("init_ready",   32'(bp_ready),   32'h0);
            check("init_pred",    32'(pred_takeD), 32'h0);
            check("init_branchD", 32'(branchD),    32'h1);
            advance();
        end
        drive(NOP, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        settle();
        check("ready_rise", 32'(bp_ready), 32'h1);
        advance();

        // Fresh tables predict taken; two not-taken trainings flip it
        drive(BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        settle();
        check("pc100_first", 32'(pred_takeD), 32'h1);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 8'h00);
            step();
        end
        drive(BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        settle();
        check("pc100_trained", 32'(pred_takeD), 32'h0);
        advance();

        // Alternating T/N branch at one PC
        for (int k = 0; k < 40; k++) begin
            act = (k % 2 == 0);
            drive(BEQ, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
            settle();
            p = m_predict(pcD, instrD);
            g = 8'(m_ghr);
            if (k >= 30) check("alt_correct", 32'(pred_takeD == act), 32'h1);
            advance();
            drive(NOP, 32'h0, 1'b0, 1'b1, 32'h200, act, p, g);
            step();
        end

        // Mispredict in M with a branch in D: recovery beats the D shift
        drive(BEQ, 32'h300, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 8'hA5);
        step();
        drive(NOP, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        settle();
`ifdef BP_GLOBAL_EN
        check("ghr_recover", 32'(ghrD), 32'h4A);
`else
        check("ghr_tied", 32'(ghrD), 32'h0);
`endif
        advance();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            ins = $urandom;
            r   = $urandom_range(0, 3);
            if (r == 0) ins[31:28] = 4'b0001;
            if (r == 1) ins[31:26] = 6'b000001;
            if (r == 2) begin
                ins[31:26] = 6'b000001;
                ins[20:18] = 3'b001;
            end
            drive(ins, 32'($urandom_range(0, 63)) << 2, ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            step();
        end

        // Mid-run reset: ready drops, GHR clears, tables re-initialise
        drive(NOP, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("rst_ready", 32'(bp_ready), 32'h0);
        check("rst_ghr",   32'(ghrD),     32'h0);
        advance();
        for (int i = 1; i < INIT_LEN; i++) step();
        drive(BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        settle();
        check("reinit_ready", 32'(bp_ready),   32'h1);
        check("reinit_pc100", 32'(pred_takeD), 32'h1);
        advance();

`ifdef BP_GLOBAL_EN
        // Chooser: local says taken, gshare says not-taken and is right
        drive(NOP, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 8'h01);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 8'h30);
            step();
        end
        drive(BEQ, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        settle();
        check("chooser_local", 32'(pred_takeD), 32'h1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(NOP, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 8'h00);
            step();
            drive(BEQ, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
            settle();
            check("chooser_global", 32'(pred_takeD), 32'h0);
            advance();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
